ipsxe_floating_point_result_checker: RTL and testbench

Receive-side checker for the floating-point example design. It accepts the result stream from the floating-point core, indexes an expected-result ROM, and compares each result against the ROM value. It also counts mismatches and flags a stall timeout. Its pass/done outputs drive board LEDs and the simulation bench verdict.

---
 rtl/ipsxe_floating_point_pkg.sv | 24 ++
 rtl/ipsxe_floating_point_result_cmp.sv | 29 ++
 rtl/ipsxe_floating_point_result_checker.sv | 136 +++++++++++++
 tb/tb_ipsxe_floating_point_result_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_pkg.sv
// Shared definitions for the floating-point example result checker:
// FSM state encoding, IEEE-754 field widths and the expected-ROM address width.
package ipsxe_floating_point_pkg;

    // Expected-ROM address width; the stimulus address counter uses it too.
    localparam int unsigned ROM_AW = 4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_TMO  = 2'd2
    } state_e;

    // Exponent field width: 8 for single, 11 for double.
    function automatic int unsigned exp_width(input int unsigned data_w);
        return (data_w == 64) ? 11 : 8;
    endfunction

    // Mantissa field width: 23 for single, 52 for double.
    function automatic int unsigned man_width(input int unsigned data_w);
        return (data_w == 64) ? 52 : 23;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_result_cmp.sv
// Combinational result/expected equality check.
// With IPSXE_FLT_CHECK_NAN_EN defined, two NaNs compare equal regardless of
// sign and payload; otherwise the compare is strictly bitwise.
module ipsxe_floating_point_result_cmp
    import ipsxe_floating_point_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_expect,
    output logic              o_match
);

`ifdef IPSXE_FLT_CHECK_NAN_EN
    localparam int unsigned EXP_W = exp_width(DATA_W);
    localparam int unsigned MAN_W = man_width(DATA_W);

    logic w_res_nan;
    logic w_exp_nan;

    // NaN: exponent all ones and mantissa nonzero.
    assign w_res_nan = (&i_result[MAN_W +: EXP_W]) && (|i_result[MAN_W-1:0]);
    assign w_exp_nan = (&i_expect[MAN_W +: EXP_W]) && (|i_expect[MAN_W-1:0]);
    assign o_match   = (i_result == i_expect) || (w_res_nan && w_exp_nan);
`else
    assign o_match = (i_result == i_expect);
`endif

endmodule

// File: rtl/ipsxe_floating_point_result_checker.sv
// Receive-side result checker: compares each incoming result beat against the
// expected ROM word, counts mismatches, and flags overrun and stall timeout.
// Optional NaN equivalence is selected with IPSXE_FLT_CHECK_NAN_EN.
module ipsxe_floating_point_result_checker
    import ipsxe_floating_point_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic [ROM_AW-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overrun,
    output logic [3:0]        err_cnt,
    output logic [3:0]        fail_addr
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(NUM_VEC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_e              r_state,     w_state_nxt;
    logic [ROM_AW-1:0]   r_rcv_cnt,   w_rcv_cnt_nxt;
    logic [IDLE_W-1:0]   r_idle,      w_idle_nxt;
    logic [3:0]          r_err_cnt,   w_err_cnt_nxt;
    logic [3:0]          r_fail_addr, w_fail_addr_nxt;
    logic                r_done,      w_done_nxt;
    logic                r_pass,      w_pass_nxt;
    logic                r_timeout,   w_timeout_nxt;
    logic                r_overrun,   w_overrun_nxt;
    logic                w_match;

    ipsxe_floating_point_result_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .i_result (s_tdata),
        .i_expect (exp_data),
        .o_match  (w_match)
    );

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_rcv_cnt   <= '0;
            r_idle      <= '0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rcv_cnt   <= w_rcv_cnt_nxt;
            r_idle      <= w_idle_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_timeout   <= w_timeout_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state logic: accept beats in RUN, watch for overrun in DONE, hold in TMO.
    always_comb begin
        w_state_nxt     = r_state;
        w_rcv_cnt_nxt   = r_rcv_cnt;
        w_idle_nxt      = r_idle;
        w_err_cnt_nxt   = r_err_cnt;
        w_fail_addr_nxt = r_fail_addr;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_timeout_nxt   = r_timeout;
        w_overrun_nxt   = r_overrun;

        unique case (r_state)
            ST_RUN: begin
                if (s_tvalid) begin
                    // A beat always wins over a timeout landing in the same cycle.
                    w_rcv_cnt_nxt = r_rcv_cnt + ROM_AW'(1);
                    w_idle_nxt    = '0;
                    if (!w_match) begin
                        if (r_err_cnt == 4'd0) begin
                            w_fail_addr_nxt = r_rcv_cnt;
                        end
                        if (r_err_cnt != 4'hF) begin
                            w_err_cnt_nxt = r_err_cnt + 4'd1;
                        end
                    end
                    if (r_rcv_cnt == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (r_err_cnt == 4'd0) && w_match;
                    end
                end else begin
                    w_idle_nxt = r_idle + IDLE_W'(1);
                    if (r_idle == IDLE_LAST) begin
                        w_state_nxt   = ST_TMO;
                        w_timeout_nxt = 1'b1;
                        w_done_nxt    = 1'b1;
                        w_pass_nxt    = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (s_tvalid) begin
                    w_overrun_nxt = 1'b1;
                    w_pass_nxt    = 1'b0;
                end
            end
            ST_TMO: begin
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign exp_addr  = r_rcv_cnt;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign overrun   = r_overrun;
    assign err_cnt   = r_err_cnt;
    assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_ipsxe_floating_point_result_checker.sv
// Self-checking bench for ipsxe_floating_point_result_checker: table-driven
// runs, hand-written corner sequences and randomized runs against a
// behavioural model. Honors IPSXE_FLT_CHECK_NAN_EN when defined.
module tb_ipsxe_floating_point_result_checker;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
    logic        done, pass, timeout, overrun;
    logic [3:0]  err_cnt, fail_addr;

    logic [31:0] rom [16];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_rcv, m_idle, m_err, m_fail;
    bit m_done, m_pass, m_tmo, m_ovr;

    assign exp_data = rom[exp_addr];

    always #5 clk = ~clk;

    ipsxe_floating_point_result_checker #(
        .DATA_W  (DATA_W),
        .NUM_VEC (NUM_VEC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .overrun   (overrun),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr)
    );

    typedef struct {
        bit          rst;
        bit          valid;
        logic [31:0] data;
        logic        e_done;
        logic        e_pass;
        logic [3:0]  e_err;
        logic [3:0]  e_fail;
        logic [3:0]  e_addr;
    } vec_t;

    function automatic bit is_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    function automatic bit ref_equal(input logic [31:0] r, input logic [31:0] e);
`ifdef IPSXE_FLT_CHECK_NAN_EN
        if (is_nan(r) && is_nan(e)) return 1'b1;
`endif
        return r == e;
    endfunction

    function automatic void model_reset();
        m_rcv = 0; m_idle = 0; m_err = 0; m_fail = 0;
        m_done = 0; m_pass = 0; m_tmo = 0; m_ovr = 0;
    endfunction

    // One clock of the checker's rules applied to the current inputs.
    function automatic void model_step(input bit v, input logic [31:0] d);
        if (m_tmo) return;
        if (m_done) begin
            if (v) begin
                m_ovr  = 1;
                m_pass = 0;
            end
            return;
        end
        if (v) begin
            if (!ref_equal(d, rom[m_rcv])) begin
                if (m_err == 0) m_fail = m_rcv;
                if (m_err < 15) m_err++;
            end
            if (m_rcv == NUM_VEC - 1) begin
                m_done = 1;
                m_pass = (m_err == 0);
            end
            m_rcv  = (m_rcv + 1) % 16;
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_tmo  = 1;
                m_done = 1;
                m_pass = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},      32'(done),      32'(m_done));
        chk({tag, ".pass"},      32'(pass),      32'(m_pass));
        chk({tag, ".timeout"},   32'(timeout),   32'(m_tmo));
        chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
        chk({tag, ".fail_addr"}, 32'(fail_addr), 32'(m_fail));
        chk({tag, ".exp_addr"},  32'(exp_addr),  32'(m_rcv));
    endtask

    task automatic do_reset(input bit v, input string tag);
        rst_n    = 1'b0;
        s_tvalid = v;
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input string tag);
        s_tvalid = v;
        s_tdata  = d;
        model_step(v, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_rom4(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] e);
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = e;
    endtask

    vec_t tbl [10];

    initial begin
        // Run A: mismatch at beat 2. Run B: all match with one idle gap.
        tbl[0] = '{1, 1, 32'h40000000, 0, 0, 4'd0, 4'd0, 4'd1};
        tbl[1] = '{0, 1, 32'h40400000, 0, 0, 4'd0, 4'd0, 4'd2};
        tbl[2] = '{0, 1, 32'h3F800001, 0, 0, 4'd1, 4'd2, 4'd3};
        tbl[3] = '{0, 1, 32'h40800000, 1, 0, 4'd1, 4'd2, 4'd4};
        tbl[4] = '{0, 0, 32'h00000000, 1, 0, 4'd1, 4'd2, 4'd4};
        tbl[5] = '{1, 1, 32'h40000000, 0, 0, 4'd0, 4'd0, 4'd1};
        tbl[6] = '{0, 0, 32'h00000000, 0, 0, 4'd0, 4'd0, 4'd1};
        tbl[7] = '{0, 1, 32'h40400000, 0, 0, 4'd0, 4'd0, 4'd2};
        tbl[8] = '{0, 1, 32'h3F800000, 0, 0, 4'd0, 4'd0, 4'd3};
        tbl[9] = '{0, 1, 32'h40800000, 1, 1, 4'd0, 4'd0, 4'd4};

        set_rom4(32'h40000000, 32'h40400000, 32'h3F800000, 32'h40800000);
        model_reset();

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset(1'b0, $sformatf("tbl%0d.reset", i));
            cycle(tbl[i].valid, tbl[i].data, $sformatf("tbl%0d.model", i));
            chk($sformatf("tbl%0d.done", i),      32'(done),      32'(tbl[i].e_done));
            chk($sformatf("tbl%0d.pass", i),      32'(pass),      32'(tbl[i].e_pass));
            chk($sformatf("tbl%0d.err_cnt", i),   32'(err_cnt),   32'(tbl[i].e_err));
            chk($sformatf("tbl%0d.fail_addr", i), 32'(fail_addr), 32'(tbl[i].e_fail));
            chk($sformatf("tbl%0d.exp_addr", i),  32'(exp_addr),  32'(tbl[i].e_addr));
        end

        // Stall: two beats then TIMEOUT idle cycles; TMO ignores later beats.
        do_reset(1'b0, "stall.reset");
        cycle(1, 32'h40000000, "stall.b0");
        cycle(1, 32'h40400000, "stall.b1");
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 32'h0, "stall.idle");
        chk("stall.pre_timeout", 32'(timeout), 32'd0);
        cycle(0, 32'h0, "stall.last_idle");
        chk("stall.timeout", 32'(timeout), 32'd1);
        chk("stall.done", 32'(done), 32'd1);
        chk("stall.addr", 32'(exp_addr), 32'd2);
        cycle(1, 32'h3F800000, "stall.ignored");
        cycle(1, 32'h12345678, "stall.ignored2");
        chk("stall.hold_addr", 32'(exp_addr), 32'd2);

        // A beat on the would-be timeout cycle is accepted instead.
        do_reset(1'b0, "race.reset");
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(0, 32'h0, "race.idle");
        cycle(1, 32'h40000000, "race.beat");
        chk("race.no_timeout", 32'(timeout), 32'd0);
        chk("race.addr", 32'(exp_addr), 32'd1);

        // Overrun after a passing run.
        do_reset(1'b0, "ovr.reset");
        for (int i = 0; i < 4; i++) cycle(1, rom[i], "ovr.beat");
        chk("ovr.pass_before", 32'(pass), 32'd1);
        cycle(1, 32'h40000000, "ovr.extra");
        chk("ovr.overrun", 32'(overrun), 32'd1);
        chk("ovr.pass_after", 32'(pass), 32'd0);
        chk("ovr.err_cnt", 32'(err_cnt), 32'd0);

        // NaN equivalence.
        set_rom4(32'h7FC00000, 32'h40400000, 32'h3F800000, 32'h40800000);
        do_reset(1'b0, "nan.reset");
        cycle(1, 32'h7FC00001, "nan.beat");
`ifdef IPSXE_FLT_CHECK_NAN_EN
        chk("nan.err_cnt", 32'(err_cnt), 32'd0);
`else
        chk("nan.err_cnt", 32'(err_cnt), 32'd1);
`endif

        // Reset mid-run with a beat presented during reset, then a fresh pass.
        set_rom4(32'h40000000, 32'h40400000, 32'h3F800000, 32'h40800000);
        do_reset(1'b0, "mid.reset0");
        cycle(1, 32'h40000000, "mid.b0");
        cycle(1, 32'hDEADBEEF, "mid.b1");
        do_reset(1'b1, "mid.reset");
        chk("mid.addr_zero", 32'(exp_addr), 32'd0);
        chk("mid.err_zero", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1, rom[i], "mid.fresh");
        chk("mid.pass", 32'(pass), 32'd1);

        // Randomized runs against the model.
        for (int run = 0; run < 24; run++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 4) == 0) rom[i] = 32'h7F800000 | $urandom_range(1, 32'h7FFFFF);
                else rom[i] = $urandom;
            end
            do_reset(1'b0, "rnd.reset");
            for (int c = 0; c < 24; c++) begin
                bit          v;
                logic [31:0] d;
                v = ($urandom_range(0, 9) < ((run % 3 == 0) ? 2 : 7));
                case ($urandom_range(0, 5))
                    0:       d = $urandom;
                    1:       d = 32'hFF800000 | $urandom_range(1, 32'h7FFFFF);
                    default: d = rom[m_rcv];
                endcase
                cycle(v, d, $sformatf("rnd%0d.c%0d", run, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
